instruction_fetch_stage: RTL and testbench

INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

---
 rtl/mips_pipeline_pkg.sv | 21 ++
 rtl/pc_register.sv | 37 +++
 rtl/instruction_fetch_stage.sv | 129 ++++++++++++
 tb/tb_instruction_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipeline_pkg.sv
// Shared fetch-pipeline types and defaults: datapath width, reset PC, bubble instruction
// and the fetch FSM encoding.
package mips_pipeline_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_FULL     = 2'd3
   } fetch_state_e;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/pc_register.sv
// Fetch PC register: redirect load wins over sequential +4 increment, otherwise holds.
// Single-cycle update; no backpressure of its own.
module pc_register
   import mips_pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_vld,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            inc_vld,
   output logic [XLEN-1:0] pc_o
);

   logic [XLEN-1:0] pc_d, pc_q;

   always_comb begin
      pc_d = pc_q;
      if (redirect_vld) begin
         pc_d = word_align(redirect_pc);
      end else if (inc_vld) begin
         pc_d = pc_q + XLEN'(4);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= word_align(RESET_PC);
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: one outstanding imem request feeding a registered 1-entry IF/ID buffer.
// Presents data the cycle after rvalid; stall holds the buffer and blocks requests while it is full.
module instruction_fetch_stage
   import mips_pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] instruction_IF_out,
   output logic [XLEN-1:0] NPC_IF_out,
   output logic            fetch_valid,
   output logic            misalign_err
);

   fetch_state_e    state_d, state_q;
   logic [XLEN-1:0] req_pc_d, req_pc_q;
   logic            discard_d, discard_q;
   logic            buf_vld_d, buf_vld_q;
   logic [XLEN-1:0] instr_d, instr_q;
   logic [XLEN-1:0] npc_d, npc_q;
   logic            misalign_d, misalign_q;

   logic [XLEN-1:0] fetch_pc;
   logic            grant, consume, capture;

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk          (clk),
      .reset        (reset),
      .redirect_vld (redirect_valid),
      .redirect_pc  (redirect_target),
      .inc_vld      (grant),
      .pc_o         (fetch_pc)
   );

   // A full buffer that is being held must not be overtaken by a new response.
   assign imem_req  = (state_q == ST_REQ) && !(buf_vld_q && stall);
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;
   assign consume   = buf_vld_q && !stall;
   assign capture   = (state_q == ST_WAIT_RSP) && imem_rvalid && !discard_q && !redirect_valid;

   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      discard_d = discard_q;
      case (state_q)
         ST_BOOT: state_d = ST_REQ;
         ST_REQ: begin
            if (grant) begin
               state_d   = ST_WAIT_RSP;
               req_pc_d  = fetch_pc;
               discard_d = redirect_valid;
            end
         end
         ST_WAIT_RSP: begin
            if (imem_rvalid) begin
               discard_d = 1'b0;
               state_d   = (capture && stall) ? ST_FULL : ST_REQ;
            end else if (redirect_valid) begin
               discard_d = 1'b1;
            end
         end
         ST_FULL: begin
            if (redirect_valid || !stall) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_comb begin
      buf_vld_d = buf_vld_q;
      instr_d   = instr_q;
      npc_d     = npc_q;
      if (consume) begin
         buf_vld_d = 1'b0;
         instr_d   = NOP_INSTR;
      end
      if (capture) begin
         buf_vld_d = 1'b1;
         instr_d   = imem_rdata;
         npc_d     = req_pc_q + XLEN'(4);
      end
      if (redirect_valid) begin
         buf_vld_d = 1'b0;
         instr_d   = NOP_INSTR;
      end
      misalign_d = redirect_valid && (redirect_target[1:0] != 2'b00);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_BOOT;
         req_pc_q   <= RESET_PC;
         discard_q  <= 1'b0;
         buf_vld_q  <= 1'b0;
         instr_q    <= NOP_INSTR;
         npc_q      <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_pc_q   <= req_pc_d;
         discard_q  <= discard_d;
         buf_vld_q  <= buf_vld_d;
         instr_q    <= instr_d;
         npc_q      <= npc_d;
         misalign_q <= misalign_d;
      end
   end

   assign instruction_IF_out = instr_q;
   assign NPC_IF_out         = npc_q;
   assign fetch_valid        = buf_vld_q;
   assign misalign_err       = misalign_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios then random stall/redirect/grant traffic
// against a transaction-level model of the fetched and presented instruction streams.
module tb_instruction_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instruction_IF_out;
   logic [31:0] NPC_IF_out;
   logic        fetch_valid;
   logic        misalign_err;

   always #5 clk = ~clk;

   instruction_fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .stall              (stall),
      .redirect_valid     (redirect_valid),
      .redirect_target    (redirect_target),
      .imem_req           (imem_req),
      .imem_addr          (imem_addr),
      .imem_gnt           (imem_gnt),
      .imem_rvalid        (imem_rvalid),
      .imem_rdata         (imem_rdata),
      .instruction_IF_out (instruction_IF_out),
      .NPC_IF_out         (NPC_IF_out),
      .fetch_valid        (fetch_valid),
      .misalign_err       (misalign_err)
   );

   int errors = 0;
   int checks = 0;

   // stimulus knobs
   logic        stall_r, rv_r;
   logic [31:0] rt_r;
   int unsigned gnt_pct;
   int          rsp_delay;

   // reference model: memory responder plus expected fetch / present addresses
   logic        pending;
   logic [31:0] pend_addr;
   int          dly;
   logic [31:0] exp_fetch_pc, exp_pres_pc;
   logic        prev_redir, exp_mis, exp_hold;
   int          consumed;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      pending      = 1'b0;
      pend_addr    = '0;
      dly          = 0;
      exp_fetch_pc = RST_PC & ~32'h3;
      exp_pres_pc  = RST_PC & ~32'h3;
      prev_redir   = 1'b0;
      exp_mis      = 1'b0;
      exp_hold     = 1'b0;
   endtask

   // One clock cycle: drive inputs after the edge, check and advance the model at negedge.
   task automatic step();
      logic grant, consume;
      @(posedge clk);
      #1;
      stall           = stall_r;
      redirect_valid  = rv_r;
      redirect_target = rt_r;
      imem_gnt        = ($urandom_range(99) < gnt_pct);
      if (pending && dly == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = memf(pend_addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
         if (pending) dly--;
      end
      @(negedge clk);

      chk("misalign", 32'(misalign_err), 32'(exp_mis));
      if (prev_redir) chk("flush_after_redirect", 32'(fetch_valid), 32'd0);
      if (exp_hold)   chk("hold_under_stall", 32'(fetch_valid), 32'd1);
      if (imem_req) begin
         chk("single_outstanding", 32'(pending), 32'd0);
         chk("imem_addr", imem_addr, exp_fetch_pc);
      end
      if (fetch_valid) begin
         chk("instr", instruction_IF_out, memf(exp_pres_pc));
         chk("npc", NPC_IF_out, exp_pres_pc + 32'd4);
      end else begin
         chk("bubble_instr", instruction_IF_out, NOP);
      end

      grant   = imem_req && imem_gnt;
      consume = fetch_valid && !stall;
      if (imem_rvalid) pending = 1'b0;
      if (grant) begin
         pending   = 1'b1;
         pend_addr = imem_addr;
         dly       = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(3));
      end
      if (consume) consumed++;
      if (redirect_valid) begin
         exp_fetch_pc = redirect_target & ~32'h3;
         exp_pres_pc  = redirect_target & ~32'h3;
      end else begin
         if (grant)   exp_fetch_pc = exp_fetch_pc + 32'd4;
         if (consume) exp_pres_pc  = exp_pres_pc + 32'd4;
      end
      exp_hold   = fetch_valid && stall && !redirect_valid;
      prev_redir = redirect_valid;
      exp_mis    = redirect_valid && (redirect_target[1:0] != 2'b00);
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      stall_r = 1'b0; rv_r = 1'b0; rt_r = '0; gnt_pct = 100; rsp_delay = 0;
      consumed = 0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_instr", instruction_IF_out, NOP);
      chk("rst_npc", NPC_IF_out, RST_PC);
      chk("rst_misalign", 32'(misalign_err), 32'd0);
      reset = 1'b1;
      #1;
      chk("boot_req", 32'(imem_req), 32'd0);

      // sequential fetch 0,4,8 with rvalid one cycle after grant; stall on the response for 8
      for (int i = 0; i < 3; i++) begin
         step();
         chk("seq_req", 32'(imem_req), 32'd1);
         chk("seq_addr", imem_addr, 32'(4 * i));
         chk("seq_valid", 32'(fetch_valid), 32'(i > 0));
         if (i > 0) chk("seq_npc", NPC_IF_out, 32'(4 * i));
         if (i == 2) stall_r = 1'b1;
         step();
         chk("seq_wait_req", 32'(imem_req), 32'd0);
         chk("seq_wait_valid", 32'(fetch_valid), 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         chk("full_req", 32'(imem_req), 32'd0);
         chk("full_valid", 32'(fetch_valid), 32'd1);
         chk("full_npc", NPC_IF_out, 32'd12);
      end
      stall_r = 1'b0;
      step();
      chk("release_valid", 32'(fetch_valid), 32'd1);
      step();
      chk("release_req", 32'(imem_req), 32'd1);
      chk("release_addr", imem_addr, 32'd12);
      step();

      // redirect while waiting on the response for 0x10
      rsp_delay = 2;
      step();
      chk("pre_redir_addr", imem_addr, 32'h10);
      chk("pre_redir_npc", NPC_IF_out, 32'h10);
      rv_r = 1'b1; rt_r = 32'h0000_0100;
      step();
      rv_r = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("drop_valid", 32'(fetch_valid), 32'd0);
      end
      rsp_delay = 0;
      rv_r = 1'b1; rt_r = 32'h0000_0102;
      step();
      rv_r = 1'b0;
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, 32'h100);
      step();
      chk("misalign_pulse", 32'(misalign_err), 32'd1);
      rv_r = 1'b1; rt_r = 32'hFFFF_FFFC;
      step();
      rv_r = 1'b0;
      chk("misalign_end", 32'(misalign_err), 32'd0);
      chk("aligned_addr", imem_addr, 32'h100);

      // wrap at the top of the address space
      step();
      step();
      chk("top_addr", imem_addr, 32'hFFFF_FFFC);
      step();
      step();
      chk("wrap_valid", 32'(fetch_valid), 32'd1);
      chk("wrap_npc", NPC_IF_out, 32'h0);
      chk("wrap_addr", imem_addr, 32'h0);
      stall_r = 1'b1;
      step();
      step();
      chk("full2_valid", 32'(fetch_valid), 32'd1);
      chk("full2_npc", NPC_IF_out, 32'd4);

      // asynchronous reset while full and stalled
      reset = 1'b0;
      #1;
      chk("arst_valid", 32'(fetch_valid), 32'd0);
      chk("arst_instr", instruction_IF_out, NOP);
      chk("arst_npc", NPC_IF_out, RST_PC);
      chk("arst_req", 32'(imem_req), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // random traffic
      gnt_pct = 60; rsp_delay = -1; consumed = 0;
      for (int c = 0; c < 3000; c++) begin
         stall_r = ($urandom_range(99) < 30);
         rv_r    = ($urandom_range(99) < 6);
         if ($urandom_range(3) == 0) rt_r = 32'hFFFF_FFF0 + 32'($urandom_range(15));
         else                        rt_r = 32'($urandom_range(32'h3FF));
         step();
      end
      chk("progress", 32'(consumed >= 50), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
